// File: rtl/fence_action_ctrl_pkg.sv
// Shared types for the fencing action controller.
//   action_state_t : controller phase, exported on state_out for debug
//   saber_state_t  : renderer-facing saber pose
//   saber_of()     : maps a phase onto the saber pose it shows
package fence_action_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_REST    = 3'd0,
        ST_BLOCK   = 3'd1,
        ST_LUNGE   = 3'd2,
        ST_ATTACK  = 3'd3,
        ST_SCORE   = 3'd4,
        ST_RECOVER = 3'd5,
        ST_WON     = 3'd6
    } action_state_t;

    typedef enum logic [1:0] {
        SABER_REST    = 2'd0,
        SABER_BLOCK   = 2'd1,
        SABER_ATTACK  = 2'd2,
        SABER_RECOVER = 2'd3
    } saber_state_t;

    function automatic saber_state_t saber_of(input action_state_t s);
        saber_state_t r;
        case (s)
            ST_REST:                r = SABER_REST;
            ST_BLOCK:               r = SABER_BLOCK;
            ST_LUNGE, ST_ATTACK:    r = SABER_ATTACK;
            default:                r = SABER_RECOVER;  // score, recover, won
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fence_action_ctrl_frame_timer.sv
// Frame-paced down counter.
//   clk, rst  : clock, async active-high reset (count -> 0)
//   clr       : force count to 0 (highest priority after reset)
//   load      : load load_val (a phase length in frames)
//   en        : frame pulse; decrements, saturating at 0
//   done      : strobe on the frame pulse that takes count from 1 to 0
//   idle      : count is 0
// A phase of N frames is loaded with N on entry, so done fires on the Nth
// frame pulse after entry; a load in the same cycle as en wins, so a frame
// coinciding with entry is not counted.
module fence_action_ctrl_frame_timer #(
    parameter int MAX = 1,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done,
    output logic         idle
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign done = en && (count == W'(1));
    assign idle = (count == '0);

endmodule

// File: rtl/fence_action_ctrl.sv
// Per-player fencing action controller.
//   clk_pixel_in   : pixel clock
//   rst_in         : async active-high reset
//   frame_in       : one-cycle frame pulse; every timer advances only on it
//   block_in, lunge_in      : gesture levels
//   hit_in, parried_in      : collision results, only looked at in ATTACK
//   opp_score_in, score_clr_in : opponent point / new match pulses
//   state_out, saber_state_out, in_attack_out, score_out,
//   score_pulse_out, match_won_out : Moore decode of the registered state
module fence_action_ctrl
    import fence_action_ctrl_pkg::*;
#(
    parameter int LUNGE_FRAMES          = 8,
    parameter int ATTACK_FRAMES         = 12,
    parameter int RECOVER_FRAMES        = 30,
    parameter int BLOCK_MAX_FRAMES      = 60,
    parameter int BLOCK_COOLDOWN_FRAMES = 20,
    parameter int WIN_SCORE             = 5,
    parameter int SCORE_W               = 4
) (
    input  logic               clk_pixel_in,
    input  logic               rst_in,
    input  logic               frame_in,
    input  logic               block_in,
    input  logic               lunge_in,
    input  logic               hit_in,
    input  logic               parried_in,
    input  logic               opp_score_in,
    input  logic               score_clr_in,
    output logic [2:0]         state_out,
    output logic [1:0]         saber_state_out,
    output logic               in_attack_out,
    output logic [SCORE_W-1:0] score_out,
    output logic               score_pulse_out,
    output logic               match_won_out
);

    localparam int M1     = (LUNGE_FRAMES > ATTACK_FRAMES) ? LUNGE_FRAMES : ATTACK_FRAMES;
    localparam int M2     = (RECOVER_FRAMES > BLOCK_MAX_FRAMES) ? RECOVER_FRAMES : BLOCK_MAX_FRAMES;
    localparam int PH_MAX = (M1 > M2) ? M1 : M2;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CD_W   = $clog2(BLOCK_COOLDOWN_FRAMES + 1);
    localparam logic [SCORE_W-1:0] WIN_SC = SCORE_W'(WIN_SCORE);

    action_state_t      state, nxt;
    logic [SCORE_W-1:0] score;
    logic               restart;    // re-enter a phase even if the state is unchanged
    logic               force_rel;  // block held too long
    logic               score_inc;
    logic               ph_entry, ph_done, ph_idle;
    logic               cd_done, cd_idle;
    logic               unused_timer;

    // Untimed states load 0 so the phase timer simply sits idle there.
    function automatic logic [PH_W-1:0] phase_len(input action_state_t s);
        logic [PH_W-1:0] r;
        case (s)
            ST_BLOCK:   r = PH_W'(BLOCK_MAX_FRAMES);
            ST_LUNGE:   r = PH_W'(LUNGE_FRAMES);
            ST_ATTACK:  r = PH_W'(ATTACK_FRAMES);
            ST_RECOVER: r = PH_W'(RECOVER_FRAMES);
            default:    r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        nxt       = state;
        restart   = 1'b0;
        force_rel = 1'b0;
        score_inc = 1'b0;
        if (score_clr_in) begin
            nxt     = ST_REST;
            restart = 1'b1;
        end else if (opp_score_in && state != ST_SCORE && state != ST_WON) begin
            nxt     = ST_RECOVER;
            restart = 1'b1;
        end else begin
            case (state)
                ST_REST:
                    if (block_in && cd_idle) nxt = ST_BLOCK;
                    else if (lunge_in)       nxt = ST_LUNGE;
                ST_BLOCK:
                    if (!block_in) nxt = ST_REST;
                    else if (ph_done) begin
                        nxt       = ST_REST;
                        force_rel = 1'b1;
                    end
                ST_LUNGE:
                    if (ph_done) nxt = ST_ATTACK;
                ST_ATTACK:
                    if (hit_in) begin
                        nxt       = ST_SCORE;
                        score_inc = 1'b1;
                    end else if (parried_in || ph_done) begin
                        nxt = ST_RECOVER;
                    end
                // score already holds the new value here
                ST_SCORE:   nxt = (score == WIN_SC) ? ST_WON : ST_RECOVER;
                ST_RECOVER: if (ph_done) nxt = ST_REST;
                ST_WON:     nxt = ST_WON;
                default:    nxt = ST_REST;
            endcase
        end
    end

    assign ph_entry = restart || (nxt != state);

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_REST;
            score <= '0;
        end else begin
            state <= nxt;
            if (score_clr_in)
                score <= '0;
            else if (score_inc && score != WIN_SC)
                score <= score + 1'b1;
        end
    end

    fence_action_ctrl_frame_timer #(.MAX(PH_MAX)) u_phase (
        .clk      (clk_pixel_in),
        .rst      (rst_in),
        .clr      (1'b0),
        .load     (ph_entry),
        .load_val (phase_len(nxt)),
        .en       (frame_in),
        .done     (ph_done),
        .idle     (ph_idle)
    );

    fence_action_ctrl_frame_timer #(.MAX(BLOCK_COOLDOWN_FRAMES)) u_cooldown (
        .clk      (clk_pixel_in),
        .rst      (rst_in),
        .clr      (score_clr_in),
        .load     (force_rel),
        .load_val (CD_W'(BLOCK_COOLDOWN_FRAMES)),
        .en       (frame_in),
        .done     (cd_done),
        .idle     (cd_idle)
    );

    assign unused_timer = ph_idle | cd_done;

    assign state_out       = state;
    assign saber_state_out = saber_of(state);
    assign in_attack_out   = (state == ST_ATTACK);
    assign score_out       = score;
    assign score_pulse_out = (state == ST_SCORE);
    assign match_won_out   = (state == ST_WON);

endmodule

// File: tb/tb_fence_action_ctrl.sv
// Scoreboard bench for fence_action_ctrl: each row drives inputs, pushes the
// outputs expected after the next edge, then pops and compares after it.
module tb_fence_action_ctrl;

    localparam int F = 1, B = 2, L = 4, H = 8, P = 16, O = 32, C = 64;
    localparam int RST = 0, BLK = 1, LNG = 2, ATK = 3, SCR = 4, REC = 5, WON = 6;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] sab;
        logic       att;
        logic [3:0] sc;
        logic       pulse;
        logic       won;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame = 0, block = 0, lunge = 0, hit = 0, parry = 0, opp = 0, clr = 0;
    logic [2:0] state_o;
    logic [1:0] saber_o;
    logic       attack_o, pulse_o, won_o;
    logic [3:0] score_o;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    fence_action_ctrl #(
        .LUNGE_FRAMES(2), .ATTACK_FRAMES(3), .RECOVER_FRAMES(4),
        .BLOCK_MAX_FRAMES(5), .BLOCK_COOLDOWN_FRAMES(3), .WIN_SCORE(2), .SCORE_W(4)
    ) dut (
        .clk_pixel_in    (clk),
        .rst_in          (rst),
        .frame_in        (frame),
        .block_in        (block),
        .lunge_in        (lunge),
        .hit_in          (hit),
        .parried_in      (parry),
        .opp_score_in    (opp),
        .score_clr_in    (clr),
        .state_out       (state_o),
        .saber_state_out (saber_o),
        .in_attack_out   (attack_o),
        .score_out       (score_o),
        .score_pulse_out (pulse_o),
        .match_won_out   (won_o)
    );

    always #5 clk = ~clk;

    // Expected outputs for a given state/score, using the documented saber table.
    function automatic exp_t mk(input int s, input int sc);
        exp_t e;
        e.st    = 3'(s);
        e.sab   = (s == RST) ? 2'd0 : (s == BLK) ? 2'd1 : (s == LNG || s == ATK) ? 2'd2 : 2'd3;
        e.att   = (s == ATK);
        e.sc    = 4'(sc);
        e.pulse = (s == SCR);
        e.won   = (s == WON);
        return e;
    endfunction

    function automatic exp_t obs();
        return {state_o, saber_o, attack_o, score_o, pulse_o, won_o};
    endfunction

    task automatic drive(input int v);
        frame = v[0]; block = v[1]; lunge = v[2]; hit = v[3];
        parry = v[4]; opp = v[5];   clr = v[6];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        rst = 1'b1;
        drive(L | B | F);
        tick();
        sb.push_back(mk(RST, 0));
        got = obs(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
        drive(0);
        #2 rst = 1'b0;
        tick();
        sb.push_back(mk(RST, 0));
        got = obs(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", got, e); end
    endtask

    task automatic test_lunge_no_hit();
        int stim[$], est[$], esc[$];
        exp_t e, got;
        stim = '{L,   0,   F,   F,   F,   F,   F,   F,   F,   F,   F,   H};
        est  = '{LNG, LNG, LNG, ATK, ATK, ATK, REC, REC, REC, REC, RST, RST};
        esc  = '{0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0};
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]); sb.push_back(mk(est[i], esc[i])); tick();
            got = obs(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL lunge_no_hit[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_hit_parry();
        int stim[$], est[$], esc[$];
        exp_t e, got;
        stim = '{L,   F,   F,   H|P, 0,   F,   F,   F,   F};
        est  = '{LNG, LNG, ATK, SCR, REC, REC, REC, REC, RST};
        esc  = '{0,   0,   0,   1,   1,   1,   1,   1,   1};
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]); sb.push_back(mk(est[i], esc[i])); tick();
            got = obs(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL hit_parry[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_win();
        int stim[$], est[$], esc[$];
        exp_t e, got;
        stim = '{L,   F,   F,   H,   0,   L,   F|L|H, O,   C,   0};
        est  = '{LNG, LNG, ATK, SCR, WON, WON, WON,   WON, RST, RST};
        esc  = '{1,   1,   1,   2,   2,   2,   2,     2,   0,   0};
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]); sb.push_back(mk(est[i], esc[i])); tick();
            got = obs(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL win[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_block_cooldown();
        int stim[$], est[$];
        exp_t e, got;
        stim = '{B,   B|F, B|F, B|F, B|F, B|F, B,   B|F, B|F, B|F, B,   0,   B|L, 0};
        est  = '{BLK, BLK, BLK, BLK, BLK, RST, RST, RST, RST, RST, BLK, RST, BLK, RST};
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]); sb.push_back(mk(est[i], 0)); tick();
            got = obs(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL block_cooldown[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_opp_score();
        int stim[$], est[$];
        exp_t e, got;
        stim = '{L,   F,   O|F, F,   F,   F,   F,   L,   O|C, F};
        est  = '{LNG, LNG, REC, REC, REC, REC, RST, LNG, RST, RST};
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]); sb.push_back(mk(est[i], 0)); tick();
            got = obs(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL opp_score[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_async_reset();
        int stim[$], est[$], esc[$];
        exp_t e, got;
        stim = '{L,   F,   F,   H,   0,   F,   F,   F,   F,   L,   F,   F};
        est  = '{LNG, LNG, ATK, SCR, REC, REC, REC, REC, RST, LNG, LNG, ATK};
        esc  = '{0,   0,   0,   1,   1,   1,   1,   1,   1,   1,   1,   1};
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i]); sb.push_back(mk(est[i], esc[i])); tick();
            got = obs(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL async_pre[%0d] got=%h exp=%h", i, got, e); end
        end
        drive(0);
        #3 rst = 1'b1;           // well between clock edges
        sb.push_back(mk(RST, 0));
        #1;
        got = obs(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL async_reset got=%h exp=%h", got, e); end
        #2 rst = 1'b0;
        drive(0);
        tick();
        sb.push_back(mk(RST, 0));
        got = obs(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL async_after got=%h exp=%h", got, e); end
    endtask

    initial begin
        test_reset();
        test_lunge_no_hit();
        test_hit_parry();
        test_win();
        test_block_cooldown();
        test_opp_score();
        test_async_reset();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fence_action_ctrl.md
# fence_action_ctrl

Per-player fencing action controller with frame-timed phases, block timeout and cooldown, saturating score and match-win detection. It sits between gesture detection (block/lunge levels), the collision and intersection detectors (hit/parry pulses) and the opponent syncer (opponent-scored pulse). It drives saber state, attack flag and score to the renderer and the link transmitter. All phase durations are parameters counted in video frames.

## Interface
Parameters:
- LUNGE_FRAMES, 8, frames spent in LUNGE before ATTACK (≥1)
- ATTACK_FRAMES, 12, maximum frames in ATTACK without hit or parry (≥1)
- RECOVER_FRAMES, 30, frames in RECOVER (≥1)
- BLOCK_MAX_FRAMES, 60, maximum continuous block before forced release (≥1)
- BLOCK_COOLDOWN_FRAMES, 20, frames after a forced release during which BLOCK cannot be entered (≥1)
- WIN_SCORE, 5, score that ends the match (≥1)
- SCORE_W, 4, score width; must hold WIN_SCORE

Ports:
- clk_pixel_in  in  1  pixel clock; the only clock
- rst_in  in  1  reset, asynchronous, active-high
- frame_in  in  1  one-cycle pulse per video frame; all timers advance only on it
- block_in  in  1  level, player holds block gesture
- lunge_in  in  1  level, player lunge gesture
- hit_in  in  1  attack path intersects opponent; used only in ATTACK
- parried_in  in  1  sabers colliding with opponent blocking; used only in ATTACK
- opp_score_in  in  1  pulse, opponent scored
- score_clr_in  in  1  pulse, new match
- state_out  out  3  current action_state_t, debug
- saber_state_out  out  2  0 rest, 1 block, 2 lunge/attack, 3 recover/score/won
- in_attack_out  out  1  high while in ATTACK
- score_out  out  SCORE_W  own score
- score_pulse_out  out  1  one cycle per point scored
- match_won_out  out  1  high while in WON

## Operation
- States: REST, BLOCK, LUNGE, ATTACK, SCORE, RECOVER, WON. Phase timer clears on every state entry.
- Timer rule: a phase of N frames ends on the Nth frame_in pulse strictly after entry, i.e. the pulse seen while timer==N-1.
- REST: block_in && cooldown==0 → BLOCK; else lunge_in → LUNGE. Block wins if both.
- BLOCK: !block_in → REST. BLOCK_MAX_FRAMES elapsed → REST with cooldown loaded to BLOCK_COOLDOWN_FRAMES.
- LUNGE: LUNGE_FRAMES elapsed → ATTACK. Inputs ignored.
- ATTACK: hit_in → SCORE (hit beats parry in the same cycle). parried_in → RECOVER. ATTACK_FRAMES elapsed → RECOVER.
- SCORE: exactly one cycle. Score increments on the ATTACK→SCORE edge, saturating at WIN_SCORE. Next state is WON if score==WIN_SCORE, else RECOVER.
- RECOVER: RECOVER_FRAMES elapsed → REST.
- WON: holds until score_clr_in.
- Cooldown decrements on each frame_in in every state and saturates at 0.
- Priority: rst_in > score_clr_in > opp_score_in > state logic.
- score_clr_in in any state: → REST, score 0, timer 0, cooldown 0.
- opp_score_in in any state except SCORE or WON: → RECOVER, timer restarted. Ignored in SCORE and WON.

## Timing
- All state, timer, cooldown and score registers reset asynchronously. Reset values: state REST, state_out 0, saber_state_out 0, in_attack_out 0, score_out 0, score_pulse_out 0, match_won_out 0.
- Outputs are decoded (Moore) from registered state. An input sampled at edge k changes outputs after edge k, giving 1-cycle latency.
- score_pulse_out is high exactly during the SCORE cycle. score_out already shows the new value in that cycle.
- frame_in coinciding with a state transition does not count toward the new state.

## Structure
- Shared package (types.svh): action_state_t (3-bit enum) and saber_state_t (2-bit enum, values as above).
- Sub-module frame_timer: parametrised frame counter, width $clog2(MAX+1), with clear, frame enable and done strobe. Instantiate one for the phase timer and one for cooldown.

## Test plan
Parameters for all scenarios: LUNGE=2, ATTACK=3, RECOVER=4, BLOCK_MAX=5, COOLDOWN=3, WIN=2.
- Lunge, no hit: lunge_in, then 2 frames → ATTACK; 3 frames → RECOVER; 4 frames → REST. score_out stays 0.
- Hit and parry same cycle in ATTACK → SCORE for 1 cycle, score_out=1, score_pulse_out=1, then RECOVER.
- Second hit → score_out=2, WON, match_won_out=1. Further lunge_in ignored. score_clr_in → REST, score 0.
- Block held 5 frames → REST. block_in still high stays REST for 3 frames, then BLOCK.
- opp_score_in during LUNGE → RECOVER with full 4 frames. opp_score_in in the same cycle as score_clr_in → REST.
- rst_in asserted mid-ATTACK, asynchronously between edges → all outputs 0 immediately, state REST.
